// File: rtl/seq_mul_responder.sv
// ============================================================================
// seq_mul_responder : multi-cycle signed multiplier, shift-add over magnitudes.
// Optional early exit when remaining multiplier is zero: SEQ_MUL_EARLY_EXIT_EN
// Revision: 1.0
// ============================================================================
`default_nettype none

module seq_mul_responder #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] result,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_FINAL = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 sign_q, sign_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic                 overflow_q, overflow_d;

    logic [WIDTH-1:0]     w_abs_x;
    logic [WIDTH-1:0]     w_abs_y;
    logic [2*WIDTH-1:0]   w_prod;
    logic [WIDTH:0]       w_prod_hi;
    logic                 w_calc_done;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            acc_q      <= '0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            cnt_q      <= '0;
            sign_q     <= 1'b0;
            result_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            cnt_q      <= cnt_d;
            sign_q     <= sign_d;
            result_q   <= result_d;
            overflow_q <= overflow_d;
        end
    end

    // Unsigned W-bit negation keeps |-2^(W-1)| exact.
    assign w_abs_x   = x[WIDTH-1] ? -x : x;
    assign w_abs_y   = y[WIDTH-1] ? -y : y;
    assign w_prod    = sign_q ? -acc_q : acc_q;
    assign w_prod_hi = w_prod[2*WIDTH-1:WIDTH-1];

`ifdef SEQ_MUL_EARLY_EXIT_EN
    assign w_calc_done = (mplier_q == '0);
`else
    assign w_calc_done = (cnt_q == CW'(WIDTH));
`endif

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        cnt_d      = cnt_q;
        sign_d     = sign_q;
        result_d   = result_q;
        overflow_d = overflow_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    mcand_d  = {{WIDTH{1'b0}}, w_abs_x};
                    mplier_d = w_abs_y;
                    acc_d    = '0;
                    cnt_d    = '0;
                    sign_d   = x[WIDTH-1] ^ y[WIDTH-1];
                    state_d  = S_CALC;
                end
            end
            S_CALC: begin
                if (w_calc_done) begin
                    state_d = S_FINAL;
                end else begin
                    // Shifting mcand each step is equivalent to adding mcand << cnt.
                    if (mplier_q[0]) begin
                        acc_d = acc_q + mcand_q;
                    end
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + CW'(1);
                end
            end
            S_FINAL: begin
                result_d   = w_prod[WIDTH-1:0];
                overflow_d = ~((&w_prod_hi) | ~(|w_prod_hi));
                state_d    = S_DONE;
            end
            S_DONE: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign req_ready = rst && (state_q == S_IDLE);
    assign rsp_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign overflow  = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_mul_responder.sv
// Randomized and directed bench for seq_mul_responder with an arithmetic reference model.
`default_nettype none

module tb_seq_mul_responder;

    localparam int W = 32;

    logic         clk;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] result;
    logic         overflow;

    int mon_total = 0;
    int mon_pass  = 0;
    int drv_total = 0;
    int drv_pass  = 0;

    seq_mul_responder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .x         (x),
        .y         (y),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .result    (result),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: full 64-bit signed product, wrapped, overflow if not sign-extension of low half.
    task automatic ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic [W-1:0] r, output logic o);
        longint p;
        longint lo;
        p  = longint'($signed(a)) * longint'($signed(b));
        r  = p[W-1:0];
        lo = longint'($signed(r));
        o  = (p != lo);
    endtask

    function automatic int ref_lat(input logic [W-1:0] b);
`ifdef SEQ_MUL_EARLY_EXIT_EN
        logic [W-1:0] mag;
        int           top;
        mag = b[W-1] ? -b : b;
        top = -1;
        for (int i = 0; i < W; i++) if (mag[i]) top = i;
        return top + 3;
`else
        return W + 2;
`endif
    endfunction

    // ---------------- compare process ----------------
    localparam int M_IDLE = 0;
    localparam int M_WAIT = 1;
    localparam int M_RESP = 2;

    int           ms = M_IDLE;
    int           waited = 0;
    bit           pa = 1'b0;
    bit           pc = 1'b0;
    logic [W-1:0] cur_r = '0;
    logic         cur_o = 1'b0;
    int           cur_lat = 0;

    task automatic mchk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        mon_total++;
        if (act === exp) mon_pass++;
        else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            ms = M_IDLE;
            pa = 1'b0;
            pc = 1'b0;
        end else if (pa) begin
            ms     = M_WAIT;
            waited = 0;
        end else if (ms == M_WAIT) begin
            waited++;
            if (waited == cur_lat) ms = M_RESP;
        end else if (ms == M_RESP && pc) begin
            ms = M_IDLE;
        end

        mchk("rsp_valid", W'(rsp_valid), W'(ms == M_RESP));
        mchk("req_ready", W'(req_ready), W'(rst && ms == M_IDLE));
        if (ms == M_RESP) begin
            mchk("result", result, cur_r);
            mchk("overflow", W'(overflow), W'(cur_o));
        end

        pa = rst && req_valid && (ms == M_IDLE);
        if (pa) begin
            ref_mul(x, y, cur_r, cur_o);
            cur_lat = ref_lat(y);
        end
        pc = rst && rsp_ready && (ms == M_RESP);
    end

    // ---------------- driver ----------------
    task automatic dchk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        drv_total++;
        if (act === exp) drv_pass++;
        else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    endtask

    task automatic txn(input logic [W-1:0] tx, input logic [W-1:0] ty, input int hold,
                       output logic [W-1:0] r, output logic o, output int lat);
        int guard;
        @(posedge clk); #1;
        x = tx;
        y = ty;
        req_valid = 1'b1;
        guard = 0;
        while (!req_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 100) dchk("accept_timeout", 1, 0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        x = $urandom;
        y = $urandom;
        lat = 0;
        while (!rsp_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        if (lat >= 100) dchk("rsp_timeout", 1, 0);
        r = result;
        o = overflow;
        for (int i = 0; i < hold; i++) begin
            req_valid = ($urandom_range(0, 1) == 1);
            x = $urandom;
            y = $urandom;
            @(posedge clk); #1;
            dchk("hold_valid", W'(rsp_valid), W'(1));
            dchk("hold_result", result, r);
            dchk("hold_ovf", W'(overflow), W'(o));
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic directed(input logic [W-1:0] tx, input logic [W-1:0] ty,
                            input logic [W-1:0] er, input logic eo, input int hold);
        logic [W-1:0] r;
        logic         o;
        int           lat;
        txn(tx, ty, hold, r, o, lat);
        dchk("dir_result", r, er);
        dchk("dir_ovf", W'(o), W'(eo));
    endtask

    logic [W-1:0] rr;
    logic         ro;
    int           rl;
    logic [W-1:0] ex_r;
    logic         ex_o;

    initial begin
        rst       = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        x         = '0;
        y         = '0;
        repeat (3) @(posedge clk);
        #1;
        dchk("rst_req_ready", W'(req_ready), W'(0));
        dchk("rst_rsp_valid", W'(rsp_valid), W'(0));
        dchk("rst_result", result, W'(0));
        dchk("rst_ovf", W'(overflow), W'(0));
        rst = 1'b1;
        @(posedge clk); #1;
        dchk("idle_req_ready", W'(req_ready), W'(1));

        directed(32'd3, 32'd5, 32'd15, 1'b0, 0);
        directed(32'h7FFFFFFF, 32'd2, 32'hFFFFFFFE, 1'b1, 0);
        directed(32'd8, -32'sd3, -32'sd24, 1'b0, 10);
        directed(-32'sd10, -32'sd20, 32'd200, 1'b0, 0);
        directed(32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1, 0);
        directed(32'h7FFFFFFF, 32'd1, 32'h7FFFFFFF, 1'b0, 0);
        directed(32'h80000000, 32'h80000000, 32'h0, 1'b1, 0);

        txn(32'd123, 32'd0, 0, rr, ro, rl);
        dchk("zero_result", rr, 32'd0);
        dchk("zero_ovf", W'(ro), W'(0));
`ifdef SEQ_MUL_EARLY_EXIT_EN
        dchk("zero_latency", rl, 2);
`else
        dchk("zero_latency", rl, 34);
`endif
        txn(32'd9, 32'd1, 0, rr, ro, rl);
        dchk("one_result", rr, 32'd9);
`ifdef SEQ_MUL_EARLY_EXIT_EN
        dchk("one_latency", rl, 3);
`else
        dchk("one_latency", rl, 34);
`endif

        // Abort a transaction mid-calculation with reset.
        @(posedge clk); #1;
        x = 32'd100;
        y = 32'd77;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        dchk("abort_req_ready", W'(req_ready), W'(0));
        dchk("abort_rsp_valid", W'(rsp_valid), W'(0));
        rst = 1'b1;
        @(posedge clk); #1;
        dchk("abort_rsp_valid2", W'(rsp_valid), W'(0));
        dchk("abort_result", result, W'(0));
        dchk("abort_ovf", W'(overflow), W'(0));
        txn(32'd6, 32'd7, 0, rr, ro, rl);
        dchk("post_rst_result", rr, 32'd42);
`ifdef SEQ_MUL_EARLY_EXIT_EN
        dchk("post_rst_latency", rl, 5);
`else
        dchk("post_rst_latency", rl, 34);
`endif

        for (int n = 0; n < 30; n++) begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            case ($urandom_range(0, 3))
                0: begin a = $urandom; b = $urandom; end
                1: begin a = W'($signed($urandom_range(0, 200)) - 100);
                         b = W'($signed($urandom_range(0, 200)) - 100); end
                2: begin a = ($urandom_range(0, 1) == 1) ? 32'h80000000 : 32'h7FFFFFFF;
                         b = W'($signed($urandom_range(0, 4)) - 2); end
                default: begin a = $urandom >> $urandom_range(0, 31);
                               b = $urandom >> $urandom_range(0, 31); end
            endcase
            txn(a, b, $urandom_range(0, 3), rr, ro, rl);
            ref_mul(a, b, ex_r, ex_o);
            dchk("rand_result", rr, ex_r);
            dchk("rand_ovf", W'(ro), W'(ex_o));
            dchk("rand_latency", rl, ref_lat(b));
        end

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", mon_pass + drv_pass, mon_total + drv_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout at %0t: got running expected finished", $time);
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
